// File: rtl/ula_pkg.sv
// ula_pkg: shared types and constants for the operand-loading path feeding
// the 16-bit bitwise units.
//   estado_t : loader FSM states (CARREGA_A, CARREGA_B, PRONTO)
//   BYTE_W   : data bus width in bits
package ula_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        CARREGA_A = 2'd0,
        CARREGA_B = 2'd1,
        PRONTO    = 2'd2
    } estado_t;

endpackage

// File: rtl/carregador_operandos_montador_palavra.sv
// montador_palavra: LARGURA-bit register written one byte lane at a time.
//   clk, rst  : clock, synchronous active-high reset (clears the word)
//   we        : write enable for this cycle
//   idx       : byte lane to write (0 = least significant)
//   byte_in   : data for the selected lane
//   palavra   : registered word; unwritten lanes hold their value
module montador_palavra
    import ula_pkg::*;
#(
    parameter int LARGURA = 16,
    parameter int IW      = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [IW-1:0]      idx,
    input  logic [BYTE_W-1:0]  byte_in,
    output logic [LARGURA-1:0] palavra
);

    always_ff @(posedge clk) begin
        if (rst) begin
            palavra <= '0;
        end else if (we) begin
            palavra[BYTE_W*idx +: BYTE_W] <= byte_in;
        end
    end

endmodule

// File: rtl/carregador_operandos.sv
// carregador_operandos: byte-serial loader assembling operands A then B
// (each LSB first) and holding them stable for the bitwise stage.
//   clk, rst             : clock, synchronous active-high reset
//   byte_in/byte_valid/byte_ready : input byte stream handshake
//   byte_par             : even-parity bit (only with CARREGADOR_PARIDADE_EN)
//   limpar               : synchronous frame abort (A/B contents kept)
//   A, B                 : registered operands
//   op_valid/op_ready    : operand handshake towards the bitwise units
//   erro                 : one-cycle pulse after a parity error
// Optional feature macro: CARREGADOR_PARIDADE_EN (parity check on bytes).
module carregador_operandos
    import ula_pkg::*;
#(
    parameter int LARGURA = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         byte_in,
`ifdef CARREGADOR_PARIDADE_EN
    input  logic               byte_par,
`endif
    input  logic               byte_valid,
    output logic               byte_ready,
    input  logic               limpar,
    output logic [LARGURA-1:0] A,
    output logic [LARGURA-1:0] B,
    output logic               op_valid,
    input  logic               op_ready,
    output logic               erro
);

    localparam int BYTES = LARGURA / BYTE_W;
    localparam int IW    = (BYTES > 1) ? $clog2(BYTES) : 1;

    estado_t       estado, estado_prox;
    logic [IW-1:0] idx, idx_prox;
    logic          aceito;
    logic          par_err;
    logic          wr_ok;
    logic          ultimo;

    // byte_ready is forced low while rst is high so nothing is consumed
    // in the reset cycle.
    assign byte_ready = !rst && (estado != PRONTO);
    assign aceito     = byte_valid && byte_ready;
    assign ultimo     = (idx == IW'(BYTES - 1));
    assign op_valid   = (estado == PRONTO);

`ifdef CARREGADOR_PARIDADE_EN
    assign par_err = aceito && !limpar && (^{byte_in, byte_par});

    always_ff @(posedge clk) begin
        if (rst) erro <= 1'b0;
        else     erro <= par_err;
    end
`else
    assign par_err = 1'b0;
    assign erro    = 1'b0;
`endif

    // a byte lands in A/B only if neither limpar nor a parity error wins
    assign wr_ok = aceito && !limpar && !par_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            estado <= CARREGA_A;
            idx    <= '0;
        end else begin
            estado <= estado_prox;
            idx    <= idx_prox;
        end
    end

    always_comb begin
        estado_prox = estado;
        idx_prox    = idx;
        if (limpar || par_err) begin
            estado_prox = CARREGA_A;
            idx_prox    = '0;
        end else begin
            case (estado)
                CARREGA_A, CARREGA_B: begin
                    if (aceito) begin
                        if (ultimo) begin
                            idx_prox    = '0;
                            estado_prox = (estado == CARREGA_A) ? CARREGA_B : PRONTO;
                        end else begin
                            idx_prox = idx + 1'b1;
                        end
                    end
                end
                PRONTO: begin
                    if (op_ready) begin
                        estado_prox = CARREGA_A;
                        idx_prox    = '0;
                    end
                end
                default: begin
                    estado_prox = CARREGA_A;
                    idx_prox    = '0;
                end
            endcase
        end
    end

    montador_palavra #(.LARGURA(LARGURA), .IW(IW)) u_mont_a (
        .clk     (clk),
        .rst     (rst),
        .we      (wr_ok && (estado == CARREGA_A)),
        .idx     (idx),
        .byte_in (byte_in),
        .palavra (A)
    );

    montador_palavra #(.LARGURA(LARGURA), .IW(IW)) u_mont_b (
        .clk     (clk),
        .rst     (rst),
        .we      (wr_ok && (estado == CARREGA_B)),
        .idx     (idx),
        .byte_in (byte_in),
        .palavra (B)
    );

endmodule

// File: tb/tb_carregador_operandos.sv
// tb_carregador_operandos: directed bench for carregador_operandos
// (LARGURA=16). Parity scenario runs when CARREGADOR_PARIDADE_EN is defined.
module tb_carregador_operandos;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  byte_in;
`ifdef CARREGADOR_PARIDADE_EN
    logic        byte_par;
`endif
    logic        byte_valid;
    logic        byte_ready;
    logic        limpar;
    logic [15:0] A, B;
    logic        op_valid;
    logic        op_ready;
    logic        erro;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit erro_seen = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (erro) erro_seen = 1;
    end

    carregador_operandos #(.LARGURA(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .byte_in    (byte_in),
`ifdef CARREGADOR_PARIDADE_EN
        .byte_par   (byte_par),
`endif
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .limpar     (limpar),
        .A          (A),
        .B          (B),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .erro       (erro)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one byte and returns #1 after the edge that accepted it.
    task automatic send_byte(input logic [7:0] b, input logic p);
        int n = 0;
        byte_in    = b;
`ifdef CARREGADOR_PARIDADE_EN
        byte_par   = p;
`endif
        byte_valid = 1'b1;
        while (!byte_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("send_timeout", 32'd1, 32'd0);
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic send_ok(input logic [7:0] b);
        send_byte(b, ^b);
    endtask

    task automatic consume();
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
    endtask

    int t0;
    bit estavel;

    initial begin
        rst = 1'b1; byte_in = '0; byte_valid = 1'b0; limpar = 1'b0; op_ready = 1'b0;
`ifdef CARREGADOR_PARIDADE_EN
        byte_par = 1'b0;
`endif
        tick();
        tick();
        chk("rst_byte_ready", byte_ready, 1'b0);
        chk("rst_A", A, 16'h0);
        chk("rst_B", B, 16'h0);
        chk("rst_op_valid", op_valid, 1'b0);
        chk("rst_erro", erro, 1'b0);
        rst = 1'b0;
        tick();
        chk("post_rst_byte_ready", byte_ready, 1'b1);

        // frame 1, back-to-back
        t0 = cyc;
        send_ok(8'h34); send_ok(8'h12); send_ok(8'hCD); send_ok(8'hAB);
        chk("f1_cycles", cyc - t0, 4);
        chk("f1_op_valid", op_valid, 1'b1);
        chk("f1_byte_ready", byte_ready, 1'b0);
        chk("f1_A", A, 16'h1234);
        chk("f1_B", B, 16'hABCD);
        estavel = 1;
        byte_in = 8'h55; byte_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (A !== 16'h1234 || B !== 16'hABCD || op_valid !== 1'b1) estavel = 0;
        end
        byte_valid = 1'b0;
        chk("f1_stable", estavel, 1'b1);

        consume();
        chk("cons_op_valid", op_valid, 1'b0);
        chk("cons_byte_ready", byte_ready, 1'b1);

        // frame 2
        send_ok(8'hFF); send_ok(8'h00); send_ok(8'h0F); send_ok(8'hF0);
        chk("f2_op_valid", op_valid, 1'b1);
        chk("f2_A", A, 16'h00FF);
        chk("f2_B", B, 16'hF00F);
        consume();

        // frame 3, one byte every other cycle
        t0 = cyc;
        send_ok(8'h78); tick();
        send_ok(8'h56); tick();
        send_ok(8'h21); tick();
        send_ok(8'h43);
        chk("f3_cycles", cyc - t0, 7);
        chk("f3_op_valid", op_valid, 1'b1);
        chk("f3_A", A, 16'h5678);
        chk("f3_B", B, 16'h4321);
        consume();

        // limpar after 3 bytes; byte in the limpar cycle must be dropped
        send_ok(8'hAA); send_ok(8'hBB); send_ok(8'hCC);
        limpar = 1'b1;
        byte_in = 8'hDD; byte_valid = 1'b1;
`ifdef CARREGADOR_PARIDADE_EN
        byte_par = ^byte_in;
`endif
        chk("limpar_byte_ready", byte_ready, 1'b1);
        tick();
        limpar = 1'b0; byte_valid = 1'b0;
        chk("limpar_op_valid", op_valid, 1'b0);
        chk("limpar_A", A, 16'hBBAA);
        chk("limpar_B", B, 16'h43CC);
        send_ok(8'h01); send_ok(8'h00); send_ok(8'h02); send_ok(8'h00);
        chk("f4_op_valid", op_valid, 1'b1);
        chk("f4_A", A, 16'h0001);
        chk("f4_B", B, 16'h0002);
        chk("no_erro", erro_seen, 1'b0);

        // rst while in PRONTO
        rst = 1'b1;
        tick();
        chk("rst2_A", A, 16'h0);
        chk("rst2_B", B, 16'h0);
        chk("rst2_op_valid", op_valid, 1'b0);
        rst = 1'b0;
        tick();
        chk("rst2_byte_ready", byte_ready, 1'b1);

`ifdef CARREGADOR_PARIDADE_EN
        // wrong parity on 2nd byte: consumed, not written, one-cycle erro
        send_ok(8'h34);
        send_byte(8'h12, 1'b1);
        chk("par_erro_hi", erro, 1'b1);
        chk("par_A_kept", A, 16'h0034);
        chk("par_op_valid", op_valid, 1'b0);
        tick();
        chk("par_erro_lo", erro, 1'b0);
        send_ok(8'h11); send_ok(8'h22); send_ok(8'h33); send_ok(8'h44);
        chk("par_f_op_valid", op_valid, 1'b1);
        chk("par_f_A", A, 16'h2211);
        chk("par_f_B", B, 16'h4433);
        consume();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
